// File: rtl/spi_wr_sched.sv
// -----------------------------------------------------------------------------
// spi_wr_sched
//
// Round-robin scheduler in front of a write-only SPI master. NREQ requesters
// share one cs/sclk/mosi bus. Each grant sends one frame: a command byte
// {1'b1, adr[6:0]} followed by NBIT data bits, MSB first. Slaves oversample
// sclk/cs with the system clock and capture mosi on rising sclk.
//
// Ports
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   req     in   [NREQ]       per-requester request level, held until ack
//   adr_in  in   [7*NREQ]     slave address, requester i at [7i+6:7i]
//   dat_in  in   [NBIT*NREQ]  write data, requester i at [NBIT*i+NBIT-1:NBIT*i]
//   ack     out  [NREQ]       one-cycle pulse: request accepted, adr/data latched
//   done    out  one-cycle pulse on the last GAP cycle after a frame
//   busy    out  high from the ack cycle until the end of GAP
//   cs      out  chip select, active-low
//   sclk    out  SPI clock, idle low
//   mosi    out  SPI data
//
// Frame timing relative to the ack cycle (cycle 0), defaults shown:
//   cs low on cycles 1..132, first rising sclk on cycle 5,
//   cs high again from cycle 133, done on cycle 140, busy low on cycle 141.
// cs/sclk/mosi are registered decodes of the state one cycle earlier, so the
// state machine runs one cycle ahead of the pins it drives.
// -----------------------------------------------------------------------------
module spi_wr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NBIT = 8,
    parameter int unsigned DIV  = 4,
    parameter int unsigned GAP  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [7*NREQ-1:0]    adr_in,
    input  logic [NBIT*NREQ-1:0] dat_in,
    output logic [NREQ-1:0]      ack,
    output logic                 done,
    output logic                 busy,
    output logic                 cs,
    output logic                 sclk,
    output logic                 mosi
);

    localparam int unsigned FrameLen = 8 + NBIT;
    localparam int unsigned PtrW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DivW     = $clog2(DIV);
    localparam int unsigned GapW     = $clog2(GAP + 1);
    localparam int unsigned BitW     = $clog2(FrameLen + 1);

    // The trailing cs time is zero extra cycles: the last sclk low phase is the
    // trailing time, so the shift state hands over straight to the gap state.
    typedef enum logic [1:0] {
        StIdle,
        StLead,
        StShift,
        StGap
    } state_e;

    state_e              state_q;
    logic [PtrW-1:0]     last_q;
    logic [FrameLen-1:0] shreg_q;
    logic [DivW-1:0]     div_q;
    logic [GapW-1:0]     gap_q;
    logic [BitW-1:0]     bit_q;
    logic                hi_q;
    logic [NREQ-1:0]     ack_q;
    logic                done_q;
    logic                busy_q;
    logic                cs_q;
    logic                sclk_q;
    logic                mosi_q;

    // -------------------------------------------------------------------------
    // Round-robin arbitration: first set request searching upward from
    // last_q + 1, wrapping. Reset value of last_q is NREQ-1 so requester 0
    // wins first.
    // -------------------------------------------------------------------------
    logic            gnt_valid;
    logic [PtrW-1:0] gnt_idx;
    logic [PtrW-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = PtrW'((32'(last_q) + k) % NREQ);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Select the granted requester's address and data.
    logic [6:0]      sel_adr;
    logic [NBIT-1:0] sel_dat;

    always_comb begin
        sel_adr = '0;
        sel_dat = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == PtrW'(i)) begin
                sel_adr = adr_in[7*i +: 7];
                sel_dat = dat_in[NBIT*i +: NBIT];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame state machine with registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= PtrW'(NREQ - 1);
            shreg_q <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            hi_q    <= 1'b0;
            ack_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            ack_q  <= '0;
            done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    cs_q   <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    if (gnt_valid) begin
                        ack_q   <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
                        busy_q  <= 1'b1;
                        shreg_q <= {1'b1, sel_adr, sel_dat};
                        last_q  <= gnt_idx;
                        div_q   <= '0;
                        state_q <= StLead;
                    end
                end

                // cs low, sclk low, first bit on mosi for DIV cycles.
                StLead: begin
                    cs_q   <= 1'b0;
                    sclk_q <= 1'b0;
                    mosi_q <= shreg_q[FrameLen-1];
                    if (div_q == DivW'(DIV - 1)) begin
                        div_q   <= '0;
                        hi_q    <= 1'b1;
                        bit_q   <= BitW'(FrameLen);
                        state_q <= StShift;
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end

                // Alternating DIV-cycle high and low phases. The shift happens at
                // the end of the high phase, so mosi and the falling sclk reach the
                // pins on the same cycle.
                StShift: begin
                    cs_q   <= 1'b0;
                    sclk_q <= hi_q;
                    mosi_q <= shreg_q[FrameLen-1];
                    if (div_q == DivW'(DIV - 1)) begin
                        div_q <= '0;
                        if (hi_q) begin
                            hi_q    <= 1'b0;
                            shreg_q <= {shreg_q[FrameLen-2:0], 1'b0};
                            bit_q   <= bit_q - BitW'(1);
                        end else if (bit_q == '0) begin
                            gap_q   <= '0;
                            state_q <= StGap;
                        end else begin
                            hi_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end

                // GAP cycles of cs high; done lands on the last one. One extra
                // state cycle keeps busy up through the done cycle, so the IDLE
                // cycle that follows is the only busy-low cycle between frames.
                StGap: begin
                    cs_q   <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    if (gap_q == GapW'(GAP - 1)) begin
                        done_q <= 1'b1;
                    end
                    if (gap_q == GapW'(GAP)) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ack  = ack_q;
    assign done = done_q;
    assign busy = busy_q;
    assign cs   = cs_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_spi_wr_sched
//
// Directed bench for spi_wr_sched with default parameters (4 requesters,
// 8 data bits, DIV=4, GAP=8). A behavioural register slave decodes the bus.
// Single-frame transactions come from a vector table; rotation, alternation,
// mid-frame reset and late data change are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_spi_wr_sched;

    localparam int NREQ = 4;
    localparam int NBIT = 8;
    // DIV*(1 + 2*(8+NBIT)) with DIV=4
    localparam int CsLow = 132;
    // cs low time plus GAP=8
    localparam int DoneDly = 140;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [7*NREQ-1:0]    adr_in;
    logic [NBIT*NREQ-1:0] dat_in;
    logic [NREQ-1:0]      ack;
    logic                 done;
    logic                 busy;
    logic                 cs;
    logic                 sclk;
    logic                 mosi;

    int n_checks;
    int n_errors;

    spi_wr_sched #(
        .NREQ(4),
        .NBIT(8),
        .DIV (4),
        .GAP (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .adr_in(adr_in),
        .dat_in(dat_in),
        .ack   (ack),
        .done  (done),
        .busy  (busy),
        .cs    (cs),
        .sclk  (sclk),
        .mosi  (mosi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Register slave model: collects bits on rising sclk while cs is low and
    // commits on cs rising only for a complete write frame.
    // ---------------------------------------------------------------------
    logic [7:0]  slv_mem [128];
    logic [15:0] slv_sh;
    int          slv_n;
    logic        slv_cs_p;
    logic        slv_sclk_p;

    initial begin
        slv_cs_p   = 1'b1;
        slv_sclk_p = 1'b0;
        slv_n      = 0;
        slv_sh     = '0;
        for (int i = 0; i < 128; i++) slv_mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (cs === 1'b0 && slv_cs_p === 1'b1) slv_n = 0;
            if (cs === 1'b0 && sclk === 1'b1 && slv_sclk_p === 1'b0) begin
                slv_sh = {slv_sh[14:0], mosi};
                slv_n++;
            end
            if (cs === 1'b1 && slv_cs_p === 1'b0) begin
                if (slv_n == 16 && slv_sh[15]) slv_mem[slv_sh[14:8]] = slv_sh[7:0];
                slv_n = 0;
            end
            slv_cs_p   = cs;
            slv_sclk_p = sclk;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one frame from the current negedge. drop: 0 keep req, 1 drop the
    // acked bit, 2 drop all. zap clears dat_in one cycle after ack.
    task automatic do_frame(input string tag, input int drop, input bit zap,
                            input logic [3:0] exp_ack, input logic [6:0] adr,
                            input logic [7:0] dat, input bit chk_idle);
        int          n;
        int          idle_n;
        int          nrise;
        int          cs_low;
        logic        sclk_p;
        logic [15:0] bits;
        logic [15:0] exp_bits;
        logic [3:0]  got;
        exp_bits = {1'b1, adr, dat};
        n = 0;
        idle_n = 0;
        while (ack === 4'b0000 && n < 400) begin
            if (busy === 1'b0) idle_n++;
            @(negedge clk);
            n++;
        end
        if (ack === 4'b0000) begin
            check({tag, " ack timeout"}, 32'(ack), 32'(exp_ack));
            return;
        end
        got = ack;
        check({tag, " ack"}, 32'(got), 32'(exp_ack));
        check({tag, " busy at ack"}, 32'(busy), 32'd1);
        if (chk_idle) check({tag, " idle cycles"}, 32'(idle_n), 32'd1);
        if (drop == 1) req = req & ~got;
        else if (drop == 2) req = '0;
        sclk_p = sclk;
        bits = '0;
        nrise = 0;
        cs_low = 0;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1 && zap) dat_in = '0;
            if (cs === 1'b0) cs_low++;
            if (sclk === 1'b1 && sclk_p === 1'b0) begin
                bits = {bits[14:0], mosi};
                nrise++;
            end
            if (ack !== 4'b0000) check({tag, " ack during frame"}, 32'(ack), 32'd0);
            sclk_p = sclk;
        end
        check({tag, " done delay"}, 32'(n), 32'(DoneDly));
        check({tag, " cs low"}, 32'(cs_low), 32'(CsLow));
        check({tag, " rising edges"}, 32'(nrise), 32'd16);
        check({tag, " bits"}, 32'(bits), 32'(exp_bits));
        check({tag, " busy at done"}, 32'(busy), 32'd1);
        check({tag, " slave reg"}, 32'(slv_mem[adr]), 32'(dat));
    endtask

    typedef struct {
        logic [3:0] req;
        logic [6:0] adr;
        logic [7:0] dat;
        logic [3:0] exp_ack;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n;
        int dones;
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        req    = '0;
        adr_in = '0;
        dat_in = '0;

        // Pointer starts at 3, then follows each grant.
        vecs[0] = '{4'b0001, 7'h01, 8'hA5, 4'b0001};
        vecs[1] = '{4'b0001, 7'h02, 8'hA5, 4'b0001};
        vecs[2] = '{4'b1001, 7'h03, 8'h3C, 4'b1000};
        vecs[3] = '{4'b0011, 7'h04, 8'h5A, 4'b0001};
        vecs[4] = '{4'b0110, 7'h05, 8'hC3, 4'b0010};
        vecs[5] = '{4'b0101, 7'h06, 8'hFF, 4'b0100};
        vecs[6] = '{4'b1001, 7'h09, 8'h00, 4'b1000};

        repeat (3) @(negedge clk);
        check("reset cs", 32'(cs), 32'd1);
        check("reset sclk", 32'(sclk), 32'd0);
        check("reset mosi", 32'(mosi), 32'd0);
        check("reset ack", 32'(ack), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            adr_in = {4{vecs[i].adr}};
            dat_in = {4{vecs[i].dat}};
            req    = vecs[i].req;
            do_frame($sformatf("vec%0d", i), 2, 1'b0, vecs[i].exp_ack, vecs[i].adr,
                     vecs[i].dat, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d busy after done", i), 32'(busy), 32'd0);
        end
        check("slave adr1 kept", 32'(slv_mem[1]), 32'hA5);
        check("slave adr2 new", 32'(slv_mem[2]), 32'hA5);

        // All four requesting, each dropping after its own ack.
        adr_in = {4{7'h10}};
        dat_in = {4{8'h81}};
        req    = 4'b1111;
        do_frame("rot0", 1, 1'b0, 4'b0001, 7'h10, 8'h81, 1'b0);
        do_frame("rot1", 1, 1'b0, 4'b0010, 7'h10, 8'h81, 1'b1);
        do_frame("rot2", 1, 1'b0, 4'b0100, 7'h10, 8'h81, 1'b1);
        do_frame("rot3", 1, 1'b0, 4'b1000, 7'h10, 8'h81, 1'b1);

        // Requesters 0 and 1 held permanently.
        req = 4'b0011;
        do_frame("alt0", 0, 1'b0, 4'b0001, 7'h10, 8'h81, 1'b1);
        do_frame("alt1", 0, 1'b0, 4'b0010, 7'h10, 8'h81, 1'b1);
        do_frame("alt2", 0, 1'b0, 4'b0001, 7'h10, 8'h81, 1'b1);
        do_frame("alt3", 0, 1'b0, 4'b0010, 7'h10, 8'h81, 1'b1);
        req = '0;

        // Reset 50 cycles after cs falls.
        adr_in = {4{7'h07}};
        dat_in = {4{8'h11}};
        req    = 4'b0001;
        n = 0;
        while (cs !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rst frame cs fell", 32'(cs), 32'd0);
        req = '0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst cs", 32'(cs), 32'd1);
        check("midrst sclk", 32'(sclk), 32'd0);
        check("midrst mosi", 32'(mosi), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        dones = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("midrst no done", 32'(dones), 32'd0);
        check("midrst slave untouched", 32'(slv_mem[7]), 32'h00);

        // Pointer was reset, so requester 2 alone gets the next grant.
        dat_in = {4{8'h22}};
        req    = 4'b0100;
        do_frame("req2", 2, 1'b0, 4'b0100, 7'h07, 8'h22, 1'b0);

        // Data changed after ack must not reach the wire.
        adr_in = {4{7'h08}};
        dat_in = {4{8'hA5}};
        req    = 4'b0001;
        do_frame("late dat", 2, 1'b1, 4'b0001, 7'h08, 8'hA5, 1'b1);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
